// File: rtl/gcd_sched.sv
// Round-robin two-requester scheduler and sequencer for a subtractive GCD datapath.
// Optional iteration watchdog enabled by defining GCD_SCHED_WATCHDOG_EN.
module gcd_sched #(
    parameter int unsigned MAX_ITER = 65535
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [1:0]  req_valid,
    input  logic [15:0] req_a0,
    input  logic [15:0] req_b0,
    input  logic [15:0] req_a1,
    input  logic [15:0] req_b1,
    output logic [1:0]  req_ready,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [15:0] rsp_gcd,
    output logic        rsp_id,
    output logic        rsp_err,
    output logic [15:0] dp_data,
    output logic        lda,
    output logic        ldb,
    output logic        sel1,
    output logic        sel2,
    output logic        sel3,
    input  logic        lt,
    input  logic        gt,
    input  logic        eq,
    input  logic [15:0] dp_a
);

    typedef enum logic [2:0] {
        IDLE,
        LOAD_A,
        LOAD_B,
        CMP,
        RESP
    } state_t;

    if (MAX_ITER < 1 || MAX_ITER > 65535) begin : g_max_iter_range
        $error("gcd_sched: MAX_ITER must be within 1..65535");
    end

    state_t      state_q, state_d;
    logic        last_grant_q, last_grant_d;
    logic        id_q, id_d;
    logic [15:0] a_q, a_d;
    logic [15:0] b_q, b_d;
    logic [15:0] gcd_q, gcd_d;

    logic        grant;
    logic        accept;
    logic [15:0] op_a;
    logic [15:0] op_b;
    logic        wd_trip;

`ifdef GCD_SCHED_WATCHDOG_EN
    localparam logic [15:0] ITER_LIMIT = 16'(MAX_ITER);

    logic [15:0] cnt_q, cnt_d;
    logic        err_q, err_d;

    assign wd_trip = (cnt_q == ITER_LIMIT) && !eq;
    assign rsp_err = err_q;
`else
    assign wd_trip = 1'b0;
    assign rsp_err = 1'b0;
`endif

    // When both requesters are valid the one not served last time wins.
    assign grant  = (&req_valid) ? ~last_grant_q : req_valid[1];
    assign accept = (state_q == IDLE) && (|req_valid);
    assign op_a   = grant ? req_a1 : req_a0;
    assign op_b   = grant ? req_b1 : req_b0;

    assign rsp_gcd = gcd_q;
    assign rsp_id  = id_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
            id_q         <= 1'b0;
            a_q          <= '0;
            b_q          <= '0;
            gcd_q        <= '0;
`ifdef GCD_SCHED_WATCHDOG_EN
            cnt_q        <= '0;
            err_q        <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            id_q         <= id_d;
            a_q          <= a_d;
            b_q          <= b_d;
            gcd_q        <= gcd_d;
`ifdef GCD_SCHED_WATCHDOG_EN
            cnt_q        <= cnt_d;
            err_q        <= err_d;
`endif
        end
    end

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        id_d         = id_q;
        a_d          = a_q;
        b_d          = b_q;
        gcd_d        = gcd_q;
`ifdef GCD_SCHED_WATCHDOG_EN
        cnt_d        = cnt_q;
        err_d        = err_q;
`endif
        case (state_q)
            IDLE: begin
                if (accept) begin
                    a_d          = op_a;
                    b_d          = op_b;
                    id_d         = grant;
                    last_grant_d = grant;
                    // A zero operand never reaches the datapath: gcd(x,0)=x.
                    if (op_a == '0 || op_b == '0) begin
                        gcd_d   = op_a | op_b;
`ifdef GCD_SCHED_WATCHDOG_EN
                        err_d   = 1'b0;
`endif
                        state_d = RESP;
                    end else begin
                        state_d = LOAD_A;
                    end
                end
            end
            LOAD_A: state_d = LOAD_B;
            LOAD_B: begin
`ifdef GCD_SCHED_WATCHDOG_EN
                cnt_d   = '0;
`endif
                state_d = CMP;
            end
            CMP: begin
                if (wd_trip) begin
                    gcd_d   = '0;
`ifdef GCD_SCHED_WATCHDOG_EN
                    err_d   = 1'b1;
`endif
                    state_d = RESP;
                end else if (eq) begin
                    gcd_d   = dp_a;
`ifdef GCD_SCHED_WATCHDOG_EN
                    err_d   = 1'b0;
`endif
                    state_d = RESP;
                end else if (gt || lt) begin
`ifdef GCD_SCHED_WATCHDOG_EN
                    cnt_d = cnt_q + 16'd1;
`endif
                end
            end
            RESP: begin
                if (rsp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        req_ready = '0;
        rsp_valid = 1'b0;
        dp_data   = '0;
        lda       = 1'b0;
        ldb       = 1'b0;
        sel1      = 1'b0;
        sel2      = 1'b0;
        sel3      = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept && rst_n) req_ready[grant] = 1'b1;
            end
            LOAD_A: begin
                sel1    = 1'b1;
                dp_data = a_q;
                lda     = 1'b1;
            end
            LOAD_B: begin
                sel1    = 1'b1;
                dp_data = b_q;
                ldb     = 1'b1;
            end
            CMP: begin
                if (!wd_trip && !eq) begin
                    if (gt) begin
                        sel2 = 1'b1;
                        lda  = 1'b1;
                    end else if (lt) begin
                        sel3 = 1'b1;
                        ldb  = 1'b1;
                    end
                end
            end
            RESP: rsp_valid = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_gcd_sched.sv
// Directed bench for gcd_sched with a behavioural subtractive GCD datapath attached.
// Expected results follow the watchdog setting chosen by GCD_SCHED_WATCHDOG_EN.
module tb_gcd_sched;

`ifdef GCD_SCHED_WATCHDOG_EN
    localparam int unsigned MI = 8;
`else
    localparam int unsigned MI = 65535;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  req_valid;
    logic [15:0] req_a0, req_b0, req_a1, req_b1;
    logic [1:0]  req_ready;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [15:0] rsp_gcd;
    logic        rsp_id;
    logic        rsp_err;
    logic [15:0] dp_data;
    logic        lda, ldb, sel1, sel2, sel3;
    logic        lt, gt, eq;
    logic [15:0] dp_a;

    int unsigned n_checks = 0;
    int unsigned n_err    = 0;

    int unsigned n_pulse;
    logic [31:0] pat;

    logic [15:0] ra = '0;
    logic [15:0] rb = '0;
    logic [15:0] subout;

    gcd_sched #(.MAX_ITER(MI)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_a0    (req_a0),
        .req_b0    (req_b0),
        .req_a1    (req_a1),
        .req_b1    (req_b1),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_gcd   (rsp_gcd),
        .rsp_id    (rsp_id),
        .rsp_err   (rsp_err),
        .dp_data   (dp_data),
        .lda       (lda),
        .ldb       (ldb),
        .sel1      (sel1),
        .sel2      (sel2),
        .sel3      (sel3),
        .lt        (lt),
        .gt        (gt),
        .eq        (eq),
        .dp_a      (dp_a)
    );

    always #5 clk = ~clk;

    // Datapath: A/B registers, X/Y operand muxes, subtractor, comparator.
    assign subout = (sel2 ? ra : rb) - (sel3 ? ra : rb);
    assign lt     = ra < rb;
    assign gt     = ra > rb;
    assign eq     = ra == rb;
    assign dp_a   = ra;

    always @(posedge clk) begin
        if (lda) ra <= sel1 ? dp_data : subout;
        if (ldb) rb <= sel1 ? dp_data : subout;
    end

    // Load pulse log: 1 = lda, 0 = ldb, most recent in bit 0.
    always @(negedge clk) begin
        if (lda) begin
            n_pulse = n_pulse + 1;
            pat     = {pat[30:0], 1'b1};
        end
        if (ldb) begin
            n_pulse = n_pulse + 1;
            pat     = {pat[30:0], 1'b0};
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
        end
    endtask

    task automatic wait_rsp(input int unsigned budget, output int unsigned n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!rsp_valid && n < budget);
    endtask

    // Starts at posedge+1 of an IDLE cycle, ends at posedge+1 after the rsp handshake.
    task automatic run_job(input string tag, input bit id, input logic [15:0] a, input logic [15:0] b,
                           input logic [15:0] exp_gcd, input int unsigned exp_lat, input bit exp_err,
                           input int unsigned exp_np, input logic [31:0] exp_pat);
        int unsigned n;
        n_pulse = 0;
        pat     = '0;
        if (id) begin
            req_a1 = a; req_b1 = b; req_valid = 2'b10;
        end else begin
            req_a0 = a; req_b0 = b; req_valid = 2'b01;
        end
        @(negedge clk);
        check({tag, " grant"}, 32'(req_ready), id ? 32'd2 : 32'd1);
        @(posedge clk);
        #1 req_valid = '0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
            if (n == 1 && exp_lat > 1) check({tag, " load_a data"}, 32'(dp_data), 32'(a));
            if (n == 2 && exp_lat > 1) check({tag, " load_b data"}, 32'(dp_data), 32'(b));
        end while (!rsp_valid && n < 70000);
        check({tag, " latency"}, n, exp_lat);
        check({tag, " gcd"}, 32'(rsp_gcd), 32'(exp_gcd));
        check({tag, " id"}, 32'(rsp_id), 32'(id));
        check({tag, " err"}, 32'(rsp_err), 32'(exp_err));
        check({tag, " pulse count"}, n_pulse, exp_np);
        check({tag, " pulse pattern"}, pat, exp_pat);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int unsigned n;
        rst_n     = 1'b0;
        req_valid = 2'b11;
        req_a0 = 16'd5; req_b0 = 16'd3; req_a1 = 16'd7; req_b1 = 16'd2;
        rsp_ready = 1'b1;
        n_pulse   = 0;
        pat       = '0;

        #12;
        check("reset req_ready", 32'(req_ready), 32'd0);
        check("reset rsp_valid", 32'(rsp_valid), 32'd0);
        check("reset rsp_gcd", 32'(rsp_gcd), 32'd0);
        check("reset rsp_id", 32'(rsp_id), 32'd0);
        check("reset rsp_err", 32'(rsp_err), 32'd0);
        check("reset ctrl", 32'({lda, ldb, sel1, sel2, sel3}), 32'd0);
        check("reset dp_data", 32'(dp_data), 32'd0);
        req_valid = '0;
        @(posedge clk);
        #3 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // 48,18: A=30, A=12, B=6, A=6, eq -> k=4
        run_job("j48_18", 1'b0, 16'd48, 16'd18, 16'd6, 8, 1'b0, 6, 32'b101101);
        run_job("j0_35", 1'b1, 16'd0, 16'd35, 16'd35, 1, 1'b0, 0, 32'd0);
        run_job("j0_0", 1'b1, 16'd0, 16'd0, 16'd0, 1, 1'b0, 0, 32'd0);

        // Round robin with both requesters held high.
        req_a0 = 16'd21; req_b0 = 16'd14; req_a1 = 16'd21; req_b1 = 16'd14;
        req_valid = 2'b11;
        for (int j = 0; j < 4; j++) begin
            n = 0;
            do begin
                @(negedge clk);
                n++;
            end while (req_ready == '0 && n < 20);
            check("rr grant", 32'(req_ready), (j % 2 == 1) ? 32'd2 : 32'd1);
            wait_rsp(50, n);
            check("rr latency", n, 6);
            check("rr gcd", 32'(rsp_gcd), 32'd7);
            check("rr id", 32'(rsp_id), 32'(j % 2));
        end
        @(posedge clk);
        #1 req_valid = '0;

        // Backpressure: 100,75 -> A=25, B=50, B=25, eq (k=3); req1 waits meanwhile.
        rsp_ready = 1'b0;
        req_a0 = 16'd100; req_b0 = 16'd75; req_valid = 2'b01;
        @(negedge clk);
        check("bp grant", 32'(req_ready), 32'd1);
        @(posedge clk);
        #1;
        req_a1 = 16'd9; req_b1 = 16'd0; req_valid = 2'b10;
        wait_rsp(50, n);
        check("bp latency", n, 7);
        check("bp gcd", 32'(rsp_gcd), 32'd25);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("bp hold valid", 32'(rsp_valid), 32'd1);
            check("bp hold gcd", 32'(rsp_gcd), 32'd25);
            check("bp hold id", 32'(rsp_id), 32'd0);
            check("bp req_ready", 32'(req_ready), 32'd0);
        end
        @(posedge clk);
        #1 rsp_ready = 1'b1;
        @(negedge clk);
        check("bp release valid", 32'(rsp_valid), 32'd1);
        @(negedge clk);
        check("bp idle grant", 32'(req_ready), 32'd2);
        @(posedge clk);
        #1 req_valid = '0;
        @(negedge clk);
        check("bp next valid", 32'(rsp_valid), 32'd1);
        check("bp next gcd", 32'(rsp_gcd), 32'd9);
        check("bp next id", 32'(rsp_id), 32'd1);
        @(posedge clk);
        #1;

        // Reset during CMP of 65535,1.
        req_a0 = 16'd65535; req_b0 = 16'd1; req_valid = 2'b01;
        @(negedge clk);
        @(posedge clk);
        #1 req_valid = '0;
        repeat (5) @(negedge clk);
        check("mid cmp lda", 32'(lda), 32'd1);
        #1 rst_n = 1'b0;
        #1;
        check("mid reset lda", 32'(lda), 32'd0);
        check("mid reset ldb", 32'(ldb), 32'd0);
        check("mid reset rsp_valid", 32'(rsp_valid), 32'd0);
        req_a0 = 16'd21; req_b0 = 16'd14; req_a1 = 16'd21; req_b1 = 16'd14;
        req_valid = 2'b11;
        #1;
        check("mid reset req_ready", 32'(req_ready), 32'd0);
        @(posedge clk);
        #3 rst_n = 1'b1;
        @(negedge clk);
        check("post reset grant", 32'(req_ready), 32'd1);
        @(posedge clk);
        #1 req_valid = '0;
        wait_rsp(50, n);
        check("post reset latency", n, 6);
        check("post reset gcd", 32'(rsp_gcd), 32'd7);
        check("post reset id", 32'(rsp_id), 32'd0);
        @(posedge clk);
        #1;

`ifdef GCD_SCHED_WATCHDOG_EN
        run_job("j65535_1", 1'b0, 16'd65535, 16'd1, 16'd0, 12, 1'b1, 10, 32'h2FF);
`else
        run_job("j65535_1", 1'b0, 16'd65535, 16'd1, 16'd1, 65538, 1'b0, 65536, 32'hFFFF_FFFF);
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/gcd_sched.md
# gcd_sched

Two-requester scheduler and sequencer for the subtractive GCD datapath (A/B registers, comparator, subtractor, bus/operand muxes). It arbitrates GCD jobs round-robin and loads operands through the datapath bus. It steps one subtraction per cycle from the comparator flags, and returns the result with a valid/ready handshake. It replaces a free-running controller with a reset-safe, backpressure-aware front end.

## Interface
- MAX_ITER, 65535: subtraction-cycle limit per job (watchdog, see Configuration)
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- req_valid  input  2  per-requester job valid
- req_a0, req_b0  input  16 each  requester 0 operands
- req_a1, req_b1  input  16 each  requester 1 operands
- req_ready  output  2  per-requester accept; one-hot or zero
- rsp_valid  output  1  result valid
- rsp_ready  input  1  result consumed
- rsp_gcd  output  16  result
- rsp_id  output  1  requester index of result
- rsp_err  output  1  job aborted by watchdog
- dp_data  output  16  to datapath data_in
- lda, ldb  output  1  datapath register loads
- sel1, sel2, sel3  output  1  bus mux (1=dp_data, 0=subout), X mux (1=A, 0=B), Y mux (1=A, 0=B)
- lt, gt, eq  input  1  datapath comparator flags (A vs B)
- dp_a  input  16  datapath register A

## Operation
- States: IDLE, LOAD_A, LOAD_B, CMP, RESP.
- Default decode in every state: lda=ldb=sel1=sel2=sel3=0, dp_data=0.
- **IDLE**
  - Grant one valid requester; req_ready[grant]=1 combinationally; operands and id are latched.
  - Arbitration: a lone valid requester wins; if both are valid, the requester other than last_grant wins; last_grant updates on accept.
  - If either operand is 0: rsp_gcd=a|b (0 when both are 0), go to RESP without touching the datapath. Otherwise go to LOAD_A.
- **LOAD_A**: sel1=1, dp_data=a, lda=1. Go to LOAD_B.
- **LOAD_B**: sel1=1, dp_data=b, ldb=1. Go to CMP; the iteration counter clears.
- **CMP**: Mealy decode from the flags.
  - gt: sel2=1, sel3=0, lda=1 (A<=A-B).
  - lt: sel2=0, sel3=1, ldb=1 (B<=B-A).
  - In both cases stay in CMP and increment the counter.
  - eq: capture rsp_gcd<=dp_a, rsp_err<=0, go to RESP; no load this cycle.
- **RESP**: rsp_valid=1. rsp_gcd, rsp_id and rsp_err hold stable until rsp_ready; on rsp_valid&&rsp_ready go to IDLE. No job is accepted in RESP; req_ready=0.
- Arithmetic is unsigned 16-bit. Zero bypass guarantees termination (no 0-operand subtract loop).

## Timing
- Reset (asynchronous, immediate):
  - state=IDLE, last_grant=1 (requester 0 wins first), counter=0.
  - rsp_valid=0, rsp_gcd=0, rsp_id=0, rsp_err=0.
  - All datapath controls 0; req_ready=0 until rst_n is released and the design is in IDLE.
- Reset mid-job: the job is dropped silently with no response. Datapath register contents are don't-care.
- Latency, with the accept at cycle 0:
  - LOAD_A at cycle 1, LOAD_B at cycle 2, first compare at cycle 3.
  - With k subtractions, eq is seen at cycle 3+k and rsp_valid rises at cycle 4+k.
  - Zero-operand job: rsp_valid at cycle 1.
- Throughput: the earliest next accept is the IDLE cycle following the rsp handshake edge.
- A requester deasserting req_valid without a handshake has no effect. req_valid must not depend on req_ready.

## Configuration
- GCD_SCHED_WATCHDOG_EN defined:
  - A 16-bit counter runs in CMP.
  - When counter==MAX_ITER and eq=0: no load is issued, rsp_gcd<=0, rsp_err<=1, go to RESP.
- GCD_SCHED_WATCHDOG_EN undefined:
  - No counter; rsp_err is tied to 0.
  - Jobs always run to eq; the worst case is 65534 subtractions.

## Test plan
- req0 a=48 b=18, rsp_ready=1 -> lda/ldb pulse sequence: lda, ldb, then lda, lda, ldb, lda. rsp_valid at cycle 8 with rsp_gcd=6, rsp_id=0, rsp_err=0.
- req1 a=0 b=35, then a=0 b=0 -> rsp_gcd=35 at cycle 1, then 0. lda/ldb are never asserted.
- Both req_valid held high for 4 jobs, operands (21,14) -> grants 0,1,0,1; every rsp_gcd=7 with matching rsp_id.
- req0 a=100 b=75 with rsp_ready=0 for 10 cycles after rsp_valid -> rsp_gcd=25 stable and req_ready=0 throughout. Release -> back to IDLE the next cycle.
- rst_n pulsed low during CMP of a=65535 b=1 -> lda/ldb and rsp_valid go 0 immediately. After release with both req_valid high -> requester 0 is granted first.
- With GCD_SCHED_WATCHDOG_EN and MAX_ITER=8: a=65535 b=1 -> rsp_valid at cycle 12, rsp_err=1, rsp_gcd=0. Without the macro -> rsp_gcd=1 at cycle 65538.
